// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module div_unit #(
    parameter int REG_WIDTH   = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             funct,
    input  logic [REG_WIDTH-1:0]   rs1_value,
    input  logic [REG_WIDTH-1:0]   rs2_value,
    input  logic [RADDR_WIDTH-1:0] rd_addr_in,
    output logic                   busy,
    output logic                   we,
    output logic [RADDR_WIDTH-1:0] rd_addr,
    output logic [REG_WIDTH-1:0]   rd_value
);

    localparam int CW = $clog2(REG_WIDTH);
    localparam logic [REG_WIDTH-1:0] SMIN = {1'b1, {(REG_WIDTH-1){1'b0}}};
    localparam logic [REG_WIDTH-1:0] ONES = '1;
    localparam logic [CW-1:0] LAST = CW'(REG_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [1:0]             funct_q;
    logic                   sign_q_q;
    logic                   sign_r_q;
    logic [REG_WIDTH-1:0]   quo_q;
    logic [REG_WIDTH-1:0]   rem_q;
    logic [REG_WIDTH-1:0]   dvs_q;
    logic [RADDR_WIDTH-1:0] addr_q;
    logic                   we_q;

    // Operand decode at accept
    logic                 is_signed;
    logic                 is_rem;
    logic                 neg1;
    logic                 neg2;
    logic [REG_WIDTH-1:0] mag1;
    logic [REG_WIDTH-1:0] mag2;
    logic                 div_zero;
    logic                 ovf;
    logic                 early;
    logic                 fast;
    logic [REG_WIDTH-1:0] fast_res;

    assign is_signed = ~funct[0];
    assign is_rem    = funct[1];
    assign neg1      = is_signed & rs1_value[REG_WIDTH-1];
    assign neg2      = is_signed & rs2_value[REG_WIDTH-1];
    assign mag1      = neg1 ? -rs1_value : rs1_value;
    assign mag2      = neg2 ? -rs2_value : rs2_value;
    assign div_zero  = (rs2_value == '0);
    assign ovf       = is_signed && (rs1_value == SMIN) && (rs2_value == ONES);

`ifdef DIV_EARLY_OUT_EN
    assign early = !div_zero && (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    assign fast = div_zero | ovf | early;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = is_rem ? rs1_value : ONES;
        end else if (ovf) begin
            fast_res = is_rem ? '0 : SMIN;
        end else if (early) begin
            fast_res = is_rem ? rs1_value : '0;
        end
    end

    // One restoring step; the partial remainder is REG_WIDTH+1 bits wide
    logic [REG_WIDTH:0]   shifted;
    logic [REG_WIDTH+1:0] diff;
    logic                 borrow;
    logic [REG_WIDTH-1:0] q_next;
    logic [REG_WIDTH-1:0] r_next;
    logic [REG_WIDTH-1:0] res_q;
    logic [REG_WIDTH-1:0] res_r;
    logic [REG_WIDTH-1:0] result;

    assign shifted = {rem_q, quo_q[REG_WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign borrow  = diff[REG_WIDTH+1];
    assign q_next  = {quo_q[REG_WIDTH-2:0], ~borrow};
    assign r_next  = borrow ? shifted[REG_WIDTH-1:0] : diff[REG_WIDTH-1:0];

    assign res_q  = (!funct_q[0] && sign_q_q) ? -q_next : q_next;
    assign res_r  = (!funct_q[0] && sign_r_q) ? -r_next : r_next;
    assign result = funct_q[1] ? res_r : res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            funct_q  <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            rd_addr  <= '0;
            rd_value <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    we_q <= 1'b0;
                    if (in_valid) begin
                        funct_q  <= funct;
                        sign_q_q <= neg1 ^ neg2;
                        sign_r_q <= neg1;
                        addr_q   <= rd_addr_in;
                        if (fast) begin
                            state    <= DONE;
                            rd_value <= fast_res;
                            rd_addr  <= rd_addr_in;
                            we_q     <= |rd_addr_in;
                        end else begin
                            state <= CALC;
                            cnt   <= '0;
                            quo_q <= mag1;
                            rem_q <= '0;
                            dvs_q <= mag2;
                        end
                    end
                end
                CALC: begin
                    quo_q <= q_next;
                    rem_q <= r_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        rd_value <= result;
                        rd_addr  <= addr_q;
                        we_q     <= |addr_q;
                    end
                end
                DONE: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving while the write is up suppresses it in that cycle
    assign we       = we_q & ~rst;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Expected values are hand-computed; latency counted in edges after accept.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  funct;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rd_addr_in;
    logic        busy;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 33;
`endif

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .rs1_value  (rs1_value),
        .rs2_value  (rs2_value),
        .rd_addr_in (rd_addr_in),
        .busy       (busy),
        .we         (we),
        .rd_addr    (rd_addr),
        .rd_value   (rd_value)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    // Issue one op and watch 40 cycles; exp_lat 0 means no write expected
    task automatic run_op(input string tag, input logic [1:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ad, input logic [31:0] exp_v,
                          input int exp_lat);
        int lat;
        int pulses;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        funct      = f;
        rs1_value  = a;
        rs2_value  = b;
        rd_addr_in = ad;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat    = 0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (we) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k + 1;
                    chk({tag, "_addr"}, 32'(rd_addr), 32'(ad));
                    chk({tag, "_val"}, rd_value, exp_v);
                end
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_pulses"}, 32'(pulses), (exp_lat == 0) ? 32'd0 : 32'd1);
        chk({tag, "_hold"}, rd_value, exp_v);
    endtask

    initial begin
        int ev;
        int acc_next;
        int wes;
        logic [4:0]  ev_addr [2];
        logic [31:0] ev_val  [2];

        rst        = 1'b1;
        in_valid   = 1'b0;
        funct      = '0;
        rs1_value  = '0;
        rs2_value  = '0;
        rd_addr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_val", rd_value, 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);

        run_op("divu", F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
        run_op("remu", F_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 33);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
        run_op("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 33);
        run_op("div_nd", F_DIV, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 33);
        run_op("div_z", F_DIV, 32'h1234_5678, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem_z", F_REM, 32'h1234_5678, 32'd0, 5'd8, 32'h1234_5678, 1);
        run_op("divu_z", F_DIVU, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1);
        run_op("divu_big", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, LAT_SMALL);
        run_op("x0", F_DIVU, 32'd10, 32'd2, 5'd0, 32'd5, 0);

        // Request 9/3 held while 100/7 is computing
        funct      = F_DIVU;
        rs1_value  = 32'd100;
        rs2_value  = 32'd7;
        rd_addr_in = 5'd5;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        rs1_value  = 32'd9;
        rs2_value  = 32'd3;
        rd_addr_in = 5'd6;
        ev         = 0;
        acc_next   = 0;
        ev_addr[0] = '0;
        ev_addr[1] = '0;
        ev_val[0]  = '0;
        ev_val[1]  = '0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (acc_next != 0) begin
                in_valid = 1'b0;
                acc_next = 0;
            end
            if (in_valid && in_ready) acc_next = 1;
            if (we) begin
                if (ev < 2) begin
                    ev_addr[ev] = rd_addr;
                    ev_val[ev]  = rd_value;
                end
                ev++;
            end
        end
        in_valid = 1'b0;
        chk("bsy_events", 32'(ev), 32'd2);
        chk("bsy_addr0", 32'(ev_addr[0]), 32'd5);
        chk("bsy_val0", ev_val[0], 32'd14);
        chk("bsy_addr1", 32'(ev_addr[1]), 32'd6);
        chk("bsy_val1", ev_val[1], 32'd3);

        // Reset at CALC step 10
        funct      = F_DIVU;
        rs1_value  = 32'd100;
        rs2_value  = 32'd7;
        rd_addr_in = 5'd5;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wes      = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (we) wes++;
        end
        chk("abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_val", rd_value, 32'd0);
        chk("abort_addr", 32'(rd_addr), 32'd0);
        for (int k = 0; k < 30; k++) begin
            if (we) wes++;
            @(posedge clk);
            #1;
        end
        chk("abort_we", 32'(wes), 32'd0);

        run_op("post_rst", F_DIVU, 32'd20, 32'd4, 5'd7, 32'd5, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
